// File: rtl/calc_sequencer.sv
// Operand/operator sequencer: captures A, opcode and B on ENTER presses, computes and holds the result.
// Optional overflow flag output is built only when CALC_OVF_FLAG_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_GET_A  | waiting for press to capture operand A (state=00)
// S_GET_OP | waiting for press to capture opcode (state=01)
// S_GET_B  | waiting for press to capture operand B (state=10)
// S_CALC   | one-cycle compute, presses ignored (state=10)
// S_SHOW   | result held on display; press chains it as A (state=11)
module calc_sequencer #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   data_in,
  input  logic           enter,
  input  logic           clear,
  output logic [1:0]     state,
  output logic [2*N-1:0] result,
  output logic [2*N-1:0] display,
  output logic           done
`ifdef CALC_OVF_FLAG_EN
  ,
  output logic           ovf
`endif
);

  typedef enum logic [2:0] {S_GET_A, S_GET_OP, S_GET_B, S_CALC, S_SHOW} st_t;

  st_t            st, st_nxt;
  logic [N-1:0]   a, a_nxt, b, b_nxt;
  logic [1:0]     op, op_nxt;
  logic [2*N-1:0] res_nxt, calc_val;
  logic [N-1:0]   diff;
  logic           done_nxt;
  logic           enter_q;
  logic           press;

  assign press = enter & ~enter_q;
  assign diff  = a - b;

  always_comb begin
    calc_val = '0;
    unique case (op)
      2'b00:   calc_val = {{N{1'b0}}, a} + {{N{1'b0}}, b};
      2'b01:   calc_val = {{N{diff[N-1]}}, diff};
      2'b10:   calc_val = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      default: calc_val = {{N{1'b0}}, a & b};
    endcase
  end

  always_comb begin
    st_nxt   = st;
    a_nxt    = a;
    b_nxt    = b;
    op_nxt   = op;
    res_nxt  = result;
    done_nxt = 1'b0;
    if (clear) begin
      st_nxt  = S_GET_A;
      a_nxt   = '0;
      b_nxt   = '0;
      op_nxt  = '0;
      res_nxt = '0;
    end else begin
      unique case (st)
        S_GET_A: if (press) begin
          a_nxt  = data_in;
          st_nxt = S_GET_OP;
        end
        S_GET_OP: if (press) begin
          op_nxt = data_in[1:0];
          st_nxt = S_GET_B;
        end
        S_GET_B: if (press) begin
          b_nxt  = data_in;
          st_nxt = S_CALC;
        end
        S_CALC: begin
          res_nxt  = calc_val;
          done_nxt = 1'b1;
          st_nxt   = S_SHOW;
        end
        S_SHOW: if (press) begin
          a_nxt  = result[N-1:0];
          st_nxt = S_GET_OP;
        end
        default: st_nxt = S_GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= S_GET_A;
      a       <= '0;
      b       <= '0;
      op      <= '0;
      result  <= '0;
      done    <= 1'b0;
      // held ENTER across reset release must not look like a press
      enter_q <= 1'b1;
    end else begin
      st      <= st_nxt;
      a       <= a_nxt;
      b       <= b_nxt;
      op      <= op_nxt;
      result  <= res_nxt;
      done    <= done_nxt;
      enter_q <= enter;
    end
  end

`ifdef CALC_OVF_FLAG_EN
  logic calc_ovf, ovf_nxt;

  always_comb begin
    calc_ovf = 1'b0;
    unique case (op)
      2'b00:   calc_ovf = calc_val[N];
      2'b01:   calc_ovf = (a < b);
      2'b10:   calc_ovf = |calc_val[2*N-1:N];
      default: calc_ovf = 1'b0;
    endcase
  end

  always_comb begin
    ovf_nxt = ovf;
    if (clear)
      ovf_nxt = 1'b0;
    else if (st == S_CALC)
      ovf_nxt = calc_ovf;
    else if (st == S_SHOW && press)
      ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf <= 1'b0;
    else       ovf <= ovf_nxt;
  end
`endif

  always_comb begin
    state = 2'b00;
    unique case (st)
      S_GET_A:          state = 2'b00;
      S_GET_OP:         state = 2'b01;
      S_GET_B, S_CALC:  state = 2'b10;
      S_SHOW:           state = 2'b11;
      default:          state = 2'b00;
    endcase
  end

  assign display = (st == S_SHOW) ? result : {{N{1'b0}}, data_in};

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (N=8): vector table plus hand sequences for reset corners.
module tb_calc_sequencer;
  localparam int N = 8;

  logic           clk, reset, enter, clear;
  logic [N-1:0]   data_in;
  logic [1:0]     state;
  logic [2*N-1:0] result, display;
  logic           done;
  logic           ovf;

  calc_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enter(enter), .clear(clear),
    .state(state), .result(result), .display(display), .done(done)
`ifdef CALC_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic           clr;
    logic [N-1:0]   d;
    logic [1:0]     st;
    logic [2*N-1:0] res;
    logic           dn;
    logic           ov;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(bit en, bit clr, int d, int st, int res, bit dn, bit ov);
    vec_t v;
    v.en = en; v.clr = clr; v.d = d[N-1:0]; v.st = st[1:0];
    v.res = res[2*N-1:0]; v.dn = dn; v.ov = ov;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ovf(string name, logic exp);
`ifdef CALC_OVF_FLAG_EN
    chk(name, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  initial begin
    logic [2*N-1:0] exp_disp;
    bit seen;

    // test 1: 25 + 17, enter held through reset first
    vecs.push_back(mk(1,0,25,   0,0,0,0));
    vecs.push_back(mk(0,0,25,   0,0,0,0));
    vecs.push_back(mk(1,0,25,   1,0,0,0));
    vecs.push_back(mk(0,0,0,    1,0,0,0));
    vecs.push_back(mk(1,0,0,    2,0,0,0));
    vecs.push_back(mk(0,0,17,   2,0,0,0));
    vecs.push_back(mk(1,0,17,   2,0,0,0));
    vecs.push_back(mk(0,0,17,   3,42,1,0));
    vecs.push_back(mk(0,0,17,   3,42,0,0));
    vecs.push_back(mk(0,1,0,    0,0,0,0));
    // test 2: 200 + 100, enter held high through CALC and SHOW
    vecs.push_back(mk(1,0,200,  1,0,0,0));
    vecs.push_back(mk(0,0,0,    1,0,0,0));
    vecs.push_back(mk(1,0,0,    2,0,0,0));
    vecs.push_back(mk(0,0,100,  2,0,0,0));
    vecs.push_back(mk(1,0,100,  2,0,0,0));
    vecs.push_back(mk(1,0,100,  3,300,1,1));
    vecs.push_back(mk(1,0,100,  3,300,0,1));
    vecs.push_back(mk(0,1,0,    0,0,0,0));
    // test 3: 3 - 5, then chain 0xFE * 4
    vecs.push_back(mk(1,0,3,    1,0,0,0));
    vecs.push_back(mk(0,0,1,    1,0,0,0));
    vecs.push_back(mk(1,0,1,    2,0,0,0));
    vecs.push_back(mk(0,0,5,    2,0,0,0));
    vecs.push_back(mk(1,0,5,    2,0,0,0));
    vecs.push_back(mk(0,0,5,    3,'hFFFE,1,1));
    vecs.push_back(mk(1,0,0,    1,'hFFFE,0,0));
    vecs.push_back(mk(0,0,2,    1,'hFFFE,0,0));
    vecs.push_back(mk(1,0,2,    2,'hFFFE,0,0));
    vecs.push_back(mk(0,0,4,    2,'hFFFE,0,0));
    vecs.push_back(mk(1,0,4,    2,'hFFFE,0,0));
    vecs.push_back(mk(0,0,4,    3,1016,1,1));
    // AND: 0xF0 & 0x3C
    vecs.push_back(mk(0,1,0,    0,0,0,0));
    vecs.push_back(mk(1,0,'hF0, 1,0,0,0));
    vecs.push_back(mk(0,0,3,    1,0,0,0));
    vecs.push_back(mk(1,0,3,    2,0,0,0));
    vecs.push_back(mk(0,0,'h3C, 2,0,0,0));
    vecs.push_back(mk(1,0,'h3C, 2,0,0,0));
    vecs.push_back(mk(0,0,'h3C, 3,'h30,1,0));
    // test 5: clear beats press in GET_B
    vecs.push_back(mk(1,0,7,    1,'h30,0,0));
    vecs.push_back(mk(0,0,0,    1,'h30,0,0));
    vecs.push_back(mk(1,0,0,    2,'h30,0,0));
    vecs.push_back(mk(0,0,9,    2,'h30,0,0));
    vecs.push_back(mk(1,1,9,    0,0,0,0));
    vecs.push_back(mk(0,0,9,    0,0,0,0));
    // MUL 20*20 -> SHOW, used for the async reset test
    vecs.push_back(mk(1,0,20,   1,0,0,0));
    vecs.push_back(mk(0,0,2,    1,0,0,0));
    vecs.push_back(mk(1,0,2,    2,0,0,0));
    vecs.push_back(mk(0,0,20,   2,0,0,0));
    vecs.push_back(mk(1,0,20,   2,0,0,0));
    vecs.push_back(mk(0,0,20,   3,400,1,1));

    reset = 1'b1; enter = 1'b1; clear = 1'b0; data_in = '0;
    #12;
    chk("reset_state",  {30'd0, state}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_done",   {31'd0, done}, 32'd0);
    chk_ovf("reset_ovf", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      enter = vecs[i].en; clear = vecs[i].clr; data_in = vecs[i].d;
      @(posedge clk);
      #1;
      exp_disp = (vecs[i].st == 2'b11) ? vecs[i].res : {{N{1'b0}}, vecs[i].d};
      chk($sformatf("v%0d_state", i),   {30'd0, state}, {30'd0, vecs[i].st});
      chk($sformatf("v%0d_result", i),  {16'd0, result}, {16'd0, vecs[i].res});
      chk($sformatf("v%0d_display", i), {16'd0, display}, {16'd0, exp_disp});
      chk($sformatf("v%0d_done", i),    {31'd0, done}, {31'd0, vecs[i].dn});
      chk_ovf($sformatf("v%0d_ovf", i), vecs[i].ov);
    end

    // test 6: async reset mid-cycle while in SHOW, enter held into release
    data_in = '0;
    enter = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("async_state",   {30'd0, state}, 32'd0);
    chk("async_result",  {16'd0, result}, 32'd0);
    chk("async_display", {16'd0, display}, 32'd0);
    chk("async_done",    {31'd0, done}, 32'd0);
    chk_ovf("async_ovf", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    data_in = 8'd5;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("held_enter_state", {30'd0, state}, 32'd0);
    end

    // recovery: 5 + 6 with bounded wait for done
    @(negedge clk) enter = 1'b0;
    @(negedge clk) enter = 1'b1;
    @(posedge clk);
    #1;
    chk("recover_state", {30'd0, state}, 32'd1);
    @(negedge clk) begin enter = 1'b0; data_in = 8'd0; end
    @(negedge clk) enter = 1'b1;
    @(negedge clk) begin enter = 1'b0; data_in = 8'd6; end
    @(negedge clk) enter = 1'b1;
    @(negedge clk) enter = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("recover_done_seen", {31'd0, seen}, 32'd1);
    chk("recover_result", {16'd0, result}, 32'd11);
    chk("recover_show", {30'd0, state}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
